// File: rtl/rnd_bounded.sv
// rnd_bounded: maps raw 32-bit random words to unbiased integers in [0, N)
// using multiply-and-reject sampling, with a small output FIFO.
module rnd_bounded #(
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      rnd_in,
    input  logic             rnd_valid,
    input  logic [OUT_W-1:0] bound,
    input  logic             bound_load,
    output logic             busy,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      reject_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 32 + OUT_W;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RUN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [OUT_W-1:0] n;
    logic [OUT_W-1:0] thr;
    logic [OUT_W-1:0] rem;
    logic [OUT_W:0]   rem_sh;
    logic [OUT_W-1:0] rem_nx;
    logic [31:0]      dvd;
    logic [4:0]       iter;

    logic [PW-1:0]    prod;
    logic             prod_valid;
    logic [31:0]      low;
    logic [OUT_W-1:0] hi;
    logic             reject;
    logic             accept;

    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             push;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: a load always wins; the divide ends after 32 iterations
    always_comb begin
        state_nx = state;
        if (bound_load)
            state_nx = (bound == '0) ? IDLE : CALC;
        else if (state == CALC && iter == 5'd31)
            state_nx = RUN;
    end

    // State-derived outputs
    always_comb begin
        busy = 1'b0;
        case (state)
            CALC:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // One restoring-division step on the remainder
    always_comb begin
        rem_sh = {rem, dvd[31]};
        if (rem_sh >= {1'b0, n})
            rem_nx = OUT_W'(rem_sh - {1'b0, n});
        else
            rem_nx = rem_sh[OUT_W-1:0];
    end

    // Bound latch and threshold divider (dividend is 2^32 - N, MSB first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n    <= '0;
            thr  <= '0;
            rem  <= '0;
            dvd  <= '0;
            iter <= '0;
        end else if (bound_load) begin
            n    <= bound;
            thr  <= '0;
            rem  <= '0;
            dvd  <= 32'd0 - 32'(bound);
            iter <= '0;
        end else if (state == CALC) begin
            rem  <= rem_nx;
            dvd  <= {dvd[30:0], 1'b0};
            iter <= iter + 5'd1;
            if (iter == 5'd31) thr <= rem_nx;
        end
    end

    // Stage 1: register the full product of the word and N
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod       <= '0;
            prod_valid <= 1'b0;
        end else if (bound_load) begin
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= (state == RUN) && rnd_valid;
            if (state == RUN && rnd_valid)
                prod <= PW'(rnd_in) * PW'(n);
        end
    end

    // Stage 2: accept/reject decision and FIFO handshake
    always_comb begin
        low       = prod[31:0];
        hi        = prod[PW-1:32];
        reject    = prod_valid && (low < 32'(thr));
        accept    = prod_valid && !reject;
        full      = (count == (AW+1)'(FIFO_DEPTH));
        out_valid = (count != '0);
        pop       = out_valid && out_ready;
        push      = accept && (!full || pop);
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // Saturating count of rejected words since the last load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            reject_count <= '0;
        else if (bound_load)
            reject_count <= '0;
        else if (reject && reject_count != 16'hFFFF)
            reject_count <= reject_count + 16'd1;
    end

    // Output FIFO; a load flushes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (bound_load) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= hi;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_rnd_bounded.sv
// tb_rnd_bounded: scoreboard bench for rnd_bounded with a
// reference model built from modular arithmetic on 64-bit integers.
module tb_rnd_bounded;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic [31:0]  rnd_in;
    logic         rnd_valid;
    logic [W-1:0] bound;
    logic         bound_load;
    logic         busy;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  reject_count;

    rnd_bounded #(.OUT_W(W), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rnd_in       (rnd_in),
        .rnd_valid    (rnd_valid),
        .bound        (bound),
        .bound_load   (bound_load),
        .busy         (busy),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .reject_count (reject_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]    exp_q[$];
    longint unsigned n_m;
    longint unsigned t_m;
    int              rej_m;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: product of word and N; low half below 2^32 mod N is rejected
    function automatic bit model_accept(input logic [31:0] w,
                                        output logic [W-1:0] h);
        longint unsigned p;
        p = 64'(w) * n_m;
        h = W'(p >> 32);
        return (p & 64'hFFFF_FFFF) >= t_m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        rnd_valid = 1'b0;
        repeat (k) tick();
    endtask

    task automatic send(input logic [31:0] w, input bit allow);
        logic [W-1:0] h;
        rnd_in    = w;
        rnd_valid = 1'b1;
        if (model_accept(w, h)) begin
            if (allow) exp_q.push_back(h);
        end else if (rej_m < 65535) begin
            rej_m++;
        end
        tick();
    endtask

    function automatic logic [31:0] acc_word();
        logic [31:0]  w;
        logic [W-1:0] h;
        w = $urandom;
        while (!model_accept(w, h)) w = $urandom;
        return w;
    endfunction

    task automatic do_load(input logic [W-1:0] b);
        rnd_valid  = 1'b0;
        bound      = b;
        bound_load = 1'b1;
        tick();
        bound_load = 1'b0;
        exp_q.delete();
        n_m   = 64'(b);
        t_m   = (b == 0) ? 64'd0 : (64'h1_0000_0000 % 64'(b));
        rej_m = 0;
        chk("flush_valid", 64'(out_valid), 0);
        chk("flush_rej", 64'(reject_count), 0);
        chk("busy_start", 64'(busy), 64'(b != 0));
    endtask

    task automatic load(input logic [W-1:0] b);
        int c;
        do_load(b);
        if (b != 0) begin
            c = 0;
            while (busy === 1'b1 && c < 40) begin
                c++;
                tick();
            end
            chk("busy_cycles", 64'(c), 32);
        end
    endtask

    task automatic drain();
        int k;
        rnd_valid = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        chk("drain_left", 64'(exp_q.size()), 0);
        tick();
        chk("drain_valid", 64'(out_valid), 0);
        chk("drain_data", 64'(out_data), 0);
    endtask

    // Monitor: every handshake pops one expected sample
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %0d required none", out_data);
            end else begin
                chk("sample", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [W-1:0] nl [6];
        rst_n      = 1'b0;
        rnd_in     = '0;
        rnd_valid  = 1'b0;
        bound      = '0;
        bound_load = 1'b0;
        out_ready  = 1'b1;
        n_m = 0; t_m = 0; rej_m = 0;
        #3;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_data", 64'(out_data), 0);
        chk("rst_rej", 64'(reject_count), 0);
        #10 rst_n = 1'b1;
        tick();

        // IDLE ignores words
        for (int i = 0; i < 6; i++) begin
            rnd_in    = $urandom;
            rnd_valid = 1'(i % 2);
            tick();
        end
        idle(2);
        chk("idle_valid", 64'(out_valid), 0);

        // N=10 directed
        load(10);
        send(32'hFFFF_FFFF, 1);
        send(32'h2000_0000, 1);
        send(32'h0000_0000, 1);
        send(32'h1999_999A, 1);
        drain();
        chk("rej_n10", 64'(reject_count), 2);

        // N=3 and N=1
        load(3);
        send(32'h0000_0000, 1);
        send(32'hFFFF_FFFF, 1);
        drain();
        chk("rej_n3", 64'(reject_count), 1);
        load(1);
        for (int i = 0; i < 5; i++) send($urandom, 1);
        send(32'h0, 1);
        drain();
        chk("rej_n1", 64'(reject_count), 0);

        // FIFO overflow with no consumer, then push+pop while full
        load(10);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(acc_word(), i < D);
        idle(3);
        chk("full_valid", 64'(out_valid), 1);
        chk("full_rej", 64'(reject_count), 0);
        chk("full_head", 64'(out_data), 64'(exp_q[0]));
        send(acc_word(), 1);
        out_ready = 1'b1;
        send(acc_word(), 1);
        drain();

        // Load mid-RUN flushes queue and in-flight word
        load(10);
        out_ready = 1'b0;
        send(acc_word(), 1);
        send(32'h0, 1);
        send(acc_word(), 1);
        send(acc_word(), 1);
        send(acc_word(), 1);
        out_ready = 1'b1;
        load(10);
        idle(6);
        chk("flushed_valid", 64'(out_valid), 0);

        // Zero bound returns to IDLE
        do_load(0);
        for (int i = 0; i < 5; i++) begin
            rnd_in    = $urandom;
            rnd_valid = 1'b1;
            tick();
        end
        idle(3);
        chk("zero_valid", 64'(out_valid), 0);
        chk("zero_busy", 64'(busy), 0);

        // Asynchronous reset mid-divide
        do_load(10);
        idle(10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 64'(busy), 0);
        chk("async_valid", 64'(out_valid), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        exp_q.delete();
        tick();
        load(10);
        send(32'hFFFF_FFFF, 1);
        send(acc_word(), 1);
        drain();

        // Randomized bounds and words, consumer always ready
        nl[0] = 10; nl[1] = 3; nl[2] = 7;
        nl[3] = 16'd40000; nl[4] = 16'hFFFF;
        nl[5] = W'($urandom_range(1, 65535));
        for (int r = 0; r < 6; r++) begin
            load(nl[r]);
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 2) == 0)
                        send(32'($urandom_range(0, 3)), 1);
                    else
                        send($urandom, 1);
                end else begin
                    idle(1);
                end
            end
            drain();
            chk("rej_rand", 64'(reject_count), 64'(rej_m));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
